// File: rtl/vid_in_frame_ctrl_if.sv
// rtl/vid_in_frame_ctrl_if.sv - tap of the bridge's m_axis_video handshake signals
interface vid_in_frame_ctrl_if;
  logic tvalid;
  logic tready;
  logic tuser;
  logic tlast;

  modport master (output tvalid, output tready, output tuser, output tlast);
  modport slave  (input tvalid, input tready, input tuser, input tlast);
endinterface

// File: rtl/vid_in_frame_ctrl.sv
// rtl/vid_in_frame_ctrl.sv - frame-level sequencer for the video-in to AXI4-Stream bridge
// Gates axis_enable on frame boundaries, checks stream geometry and resyncs after overflow.
module vid_in_frame_ctrl #(
  parameter int HSIZE_BITS  = 12,
  parameter int VSIZE_BITS  = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FCNT_BITS   = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  ctrl_enable,
  input  logic                  ctrl_clear_err,
  input  logic [HSIZE_BITS-1:0] cfg_hsize,
  input  logic [VSIZE_BITS-1:0] cfg_vsize,
  input  logic                  vtd_vblank,
  input  logic                  wr_error,
  vid_in_frame_ctrl_if.slave    axis,
  output logic                  axis_enable,
  output logic                  locked,
  output logic                  frame_done,
  output logic [FCNT_BITS-1:0]  frame_count,
  output logic                  err_line_len,
  output logic                  err_frame_len,
  output logic                  err_overflow,
  output logic [2:0]            state
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_VB  = 3'd1,
    S_WAIT_SOF = 3'd2,
    S_ACTIVE   = 3'd3,
    S_RESYNC   = 3'd4
  } state_t;

  state_t cur;

  logic [SS-1:0] vb_sync;
  logic [SS-1:0] we_sync;
  logic          vb_d;
  logic          we_d;
  logic          vb_rise;
  logic          we_rise;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vb_sync <= '0;
      we_sync <= '0;
      vb_d    <= 1'b0;
      we_d    <= 1'b0;
    end else begin
      vb_sync <= {vb_sync[SS-2:0], vtd_vblank};
      we_sync <= {we_sync[SS-2:0], wr_error};
      vb_d    <= vb_sync[SS-1];
      we_d    <= we_sync[SS-1];
    end
  end

  assign vb_rise = vb_sync[SS-1] & ~vb_d;
  assign we_rise = we_sync[SS-1] & ~we_d;

  logic [HSIZE_BITS-1:0] hsize_l;
  logic [HSIZE_BITS-1:0] pix;
  logic [HSIZE_BITS-1:0] pix_base;
  logic [HSIZE_BITS-1:0] pix_inc;
  logic [HSIZE_BITS-1:0] pix_sat;
  logic [VSIZE_BITS-1:0] vsize_l;
  logic [VSIZE_BITS-1:0] line;
  logic [VSIZE_BITS-1:0] line_base;
  logic [VSIZE_BITS-1:0] line_inc;
  logic                  frame_err;
  logic                  beat;
  logic                  sof_beat;
  logic                  early_sof;
  logic                  line_bad;
  logic                  frame_end;
  logic                  err_this;
  logic                  take;

  // A SOF beat always starts a fresh frame, so its counts are taken from zero.
  assign beat      = axis.tvalid & axis.tready;
  assign sof_beat  = beat & axis.tuser;
  assign pix_base  = sof_beat ? '0 : pix;
  assign line_base = sof_beat ? '0 : line;
  assign pix_inc   = pix_base + 1'b1;
  assign pix_sat   = (&pix_base) ? pix_base : pix_inc;
  assign line_inc  = line_base + 1'b1;
  assign line_bad  = axis.tlast && (pix_inc != hsize_l);
  assign frame_end = axis.tlast && (line_inc == vsize_l);
  assign early_sof = (cur == S_ACTIVE) && sof_beat && ((pix != '0) || (line != '0));
  assign err_this  = (frame_err & ~sof_beat) | line_bad;
  assign take      = ((cur == S_WAIT_SOF) && ctrl_enable && sof_beat) ||
                     ((cur == S_ACTIVE) && beat);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cur           <= S_IDLE;
      hsize_l       <= '0;
      vsize_l       <= '0;
      pix           <= '0;
      line          <= '0;
      frame_err     <= 1'b0;
      axis_enable   <= 1'b0;
      locked        <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      axis_enable <= (cur == S_WAIT_SOF) || (cur == S_ACTIVE);

      // Clears come first so that a simultaneous set below takes precedence.
      if (ctrl_clear_err) begin
        err_line_len  <= 1'b0;
        err_frame_len <= 1'b0;
        err_overflow  <= 1'b0;
      end
      if (we_rise) begin
        err_overflow <= 1'b1;
      end

      if (we_rise && (cur != S_IDLE)) begin
        cur    <= S_RESYNC;
        locked <= 1'b0;
      end else begin
        case (cur)
          S_IDLE: begin
            if (ctrl_enable && (cfg_hsize != '0) && (cfg_vsize != '0)) begin
              cur <= S_WAIT_VB;
            end
          end
          S_WAIT_VB: begin
            if (!ctrl_enable) begin
              cur    <= S_IDLE;
              locked <= 1'b0;
            end else if (vb_rise) begin
              hsize_l <= cfg_hsize;
              vsize_l <= cfg_vsize;
              cur     <= S_WAIT_SOF;
            end
          end
          S_WAIT_SOF: begin
            if (!ctrl_enable) begin
              cur    <= S_IDLE;
              locked <= 1'b0;
            end
          end
          S_RESYNC: begin
            cur <= ctrl_enable ? S_WAIT_VB : S_IDLE;
          end
          default: ;
        endcase

        // ctrl_enable is ignored in ACTIVE until the frame in flight completes.
        if (take) begin
          frame_err <= err_this;
          if (early_sof) begin
            err_frame_len <= 1'b1;
            locked        <= 1'b0;
          end
          if (line_bad) begin
            err_line_len <= 1'b1;
            locked       <= 1'b0;
          end
          if (axis.tlast) begin
            pix <= '0;
            if (frame_end) begin
              line        <= '0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
              locked      <= ctrl_enable & ~err_this;
              cur         <= ctrl_enable ? S_WAIT_SOF : S_IDLE;
            end else begin
              line <= line_inc;
              cur  <= S_ACTIVE;
            end
          end else begin
            pix  <= pix_sat;
            line <= line_base;
            cur  <= S_ACTIVE;
          end
        end
      end
    end
  end

  assign state = cur;

endmodule
